// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared types and helpers for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    function automatic int cnt_w(int width);
        return $clog2(width + 1);
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_sub_fs.sv
`default_nettype none
// ============================================================================
// Module   : fs
// Brief    : Combinational 1-bit full subtractor (d = a - b - bin).
// Revision : 1.0 - initial release
// ============================================================================
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fs
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial unsigned subtractor, LSB first, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int c_cnt_w = cnt_w(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    sub_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               br_q, br_d;

    logic               w_fs_d;
    logic               w_fs_bout;
    logic [WIDTH-1:0]   w_result_shift;

    fs u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (w_fs_d),
        .bout (w_fs_bout)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_result_shift = w_fs_d;
        end else begin : g_shift_wn
            assign w_result_shift = {w_fs_d, result_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    br_d     = bin;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                br_d     = w_fs_bout;
                result_d = w_result_shift;
                cnt_d    = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // rst gates in_ready so no operand is offered acceptance during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign diff      = result_q;
    assign bout      = br_q;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Directed self-checking bench for serial_sub (WIDTH 8 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, bout8;

    logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       bin4 = 1'b0, bout4;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8),
        .out_ready(out_ready8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4),
        .out_ready(out_ready4), .diff(diff4), .bout(bout4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid8, returning edges elapsed since acceptance.
    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run8(input logic [7:0] a_i, input logic [7:0] b_i, input logic bin_i,
                        input logic [7:0] exp_d, input logic exp_b, input string tag);
        int lat;
        in_valid8 = 1'b1; a8 = a_i; b8 = b_i; bin8 = bin_i; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        wait_done8(lat);
        check({tag, " latency"}, lat, 8);
        check({tag, " diff"}, diff8, exp_d);
        check({tag, " bout"}, bout8, exp_b);
        tick();
        check({tag, " out_valid drop"}, out_valid8, 1'b0);
        check({tag, " in_ready back"}, in_ready8, 1'b1);
    endtask

    initial begin
        int lat;
        logic [7:0] hold_d;
        logic       hold_b;

        rst = 1'b1;
        tick();
        tick();
        check("reset out_valid", out_valid8, 1'b0);
        check("reset diff", diff8, 8'h00);
        check("reset bout", bout8, 1'b0);
        check("reset in_ready", in_ready8, 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", in_ready8, 1'b1);

        run8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "no_borrow");
        run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "borrow_out");
        run8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "borrow_out_bin");
        run8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "bin_consumed");

        // Backpressure: result held in DONE while new operands are offered.
        in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        wait_done8(lat);
        check("bp latency", lat, 8);
        check("bp diff", diff8, 8'h22);
        check("bp bout", bout8, 1'b0);
        hold_d = diff8;
        hold_b = bout8;
        in_valid8 = 1'b1; a8 = 8'h20; b8 = 8'h30; bin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp out_valid held", out_valid8, 1'b1);
            check("bp in_ready low", in_ready8, 1'b0);
            check("bp diff stable", diff8, hold_d);
            check("bp bout stable", bout8, hold_b);
        end
        out_ready8 = 1'b1;
        tick();
        check("bp after hs out_valid", out_valid8, 1'b0);
        check("bp after hs in_ready", in_ready8, 1'b1);
        tick();
        check("bp new accepted", in_ready8, 1'b0);
        in_valid8 = 1'b0;
        wait_done8(lat);
        check("bp new latency", lat, 8);
        check("bp new diff", diff8, 8'hEF);
        check("bp new bout", bout8, 1'b1);
        tick();

        // Reset during SHIFT at bit 3.
        in_valid8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst out_valid", out_valid8, 1'b0);
        check("midrst diff", diff8, 8'h00);
        check("midrst bout", bout8, 1'b0);
        check("midrst in_ready", in_ready8, 1'b1);
        run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "post_rst");

        // Exhaustive WIDTH=4 sweep with random consumer stalls.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int cv = 0; cv < 2; cv++) begin
                    int exp_d;
                    int exp_b;
                    int lat4;
                    exp_d = (av - bv - cv) & 15;
                    exp_b = (av < bv + cv) ? 1 : 0;
                    in_valid4 = 1'b1; a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(cv);
                    out_ready4 = 1'($urandom_range(0, 1));
                    tick();
                    in_valid4 = 1'b0;
                    lat4 = 0;
                    while (!out_valid4 && lat4 < 20) begin
                        out_ready4 = 1'b0;
                        tick();
                        lat4++;
                    end
                    check("w4 latency", lat4, 4);
                    check("w4 diff", diff4, exp_d);
                    check("w4 bout", bout4, exp_b);
                    repeat ($urandom_range(0, 2)) tick();
                    out_ready4 = 1'b1;
                    tick();
                    out_ready4 = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_sub
`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor with borrow-in and borrow-out. It computes `diff = a - b - bin` one bit per clock, LSB first, using a single 1-bit full subtractor and a borrow flip-flop. It serves area-constrained datapaths that already use the combinational full-adder cells, and provides the inverse arithmetic operation behind valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal for WIDTH ≥ 1.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`, `b` and `bin` are valid.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `bin` input 1: borrow-in.
- `out_valid` output 1: `diff` and `bout` are valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` output 1: 1 if and only if `a < b + bin`, evaluated as unsigned integers.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`:
    - capture `a` and `b` into shift registers;
    - set the borrow flip-flop to `bin`;
    - set the bit counter to 0;
    - go to SHIFT.
- **SHIFT** (`in_ready` = 0), one bit per cycle:
  - Bit rule: `d = a0 ^ b0 ^ br` and `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`.
  - Shift `d` into the MSB of the result register, shifting the register right.
  - Shift the `a` and `b` registers right by one.
  - Increment the counter.
  - When the counter reaches WIDTH-1 and that bit is processed, go to DONE.
- **DONE**
  - `out_valid` = 1.
  - `diff` is the result register; `bout` is the final borrow.
  - Both are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. Operands do not need to be held after acceptance.
- `out_valid` never deasserts without a handshake, except on reset.
- The counter width is `$clog2(WIDTH+1)`.
- **WIDTH = 1:** exactly one SHIFT cycle.
- **Reset:** applies in any state, including mid-SHIFT.
  - FSM goes to IDLE; the partial result is discarded.
  - Counter, borrow flip-flop and result register clear to 0.
  - While `rst` is high, `in_ready` = 0.

## Timing
- **Reset values:** `out_valid` = 0, `diff` = 0, `bout` = 0, `in_ready` = 0 while `rst` is high. `in_ready` = 1 in the first cycle after `rst` is released.
- **Latency:** if operands are accepted at edge E0, `out_valid` is first high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- **Throughput:** one operation per WIDTH+2 cycles at best (WIDTH SHIFT cycles + DONE + IDLE). There is no overlap of accept and result.
- **Outputs:** `in_ready` and `out_valid` are decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- **Shared package `serial_sub_pkg`:**
  - state enum `sub_state_t` {IDLE, SHIFT, DONE};
  - `function automatic cnt_w(int width)` returning `$clog2(width+1)`.
- **Sub-module `fs`:** combinational 1-bit full subtractor.
  - Ports: inputs `a`, `b`, `bin`; outputs `d`, `bout`.
  - Instantiated once in the datapath.
- **Top level:** FSM, counter, operand and result shift registers, borrow flip-flop.

## Test plan
1. **No borrow:** WIDTH=8, `a`=0x5A, `b`=0x3C, `bin`=0, `out_ready`=1 → `diff`=0x1E, `bout`=0. `out_valid` rises exactly 8 cycles after acceptance and is high for 1 cycle.
2. **Borrow out:** `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1. Then `a`=0x00, `b`=0xFF, `bin`=1 → `diff`=0x00, `bout`=1.
3. **Borrow-in consumed:** `a`=0x10, `b`=0x0F, `bin`=1 → `diff`=0x00, `bout`=0.
4. **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands.
   - `diff`/`bout` stay stable and `in_ready` stays 0.
   - After the handshake, `in_ready`=1 on the next cycle and the new operands are accepted.
5. **Reset mid-operation:** assert `rst` for 1 cycle at SHIFT bit 3.
   - Next cycle: `out_valid`=0, `diff`=0, `bout`=0, `in_ready`=1.
   - A following operation 0x80-0x01 → `diff`=0x7F, `bout`=0.
6. **Exhaustive:** WIDTH=4, all 512 combinations of (`a`, `b`, `bin`) with random `out_ready` stalls.
   - Each result checked against a model of `(a - b - bin) mod 16` and `bout = (a < b + bin)`.
   - Latency is always 4 cycles.
